// File: rtl/term_text_writer.sv
// term_text_writer
//   Terminal write controller sitting between the UART receiver and the
//   character-cell text RAM (16K x 7, write port A). Accepts bytes over a
//   valid/ready handshake, tracks the cursor, interprets CR/LF/BS, writes
//   printable characters, auto-wraps at end of line and scrolls by rotating
//   a circular row base instead of copying lines.
//
//   Ports:
//     clk          system clock (also RAM clka)
//     reset        asynchronous, active-high reset
//     rx_data      received byte
//     rx_valid     rx_data valid
//     rx_ready     writer can accept a byte this cycle
//     wr_en        RAM write strobe (cea)
//     wr_addr      RAM address {phys_row[6:0], col[6:0]} (ada)
//     wr_data      character code (din)
//     cursor_row   screen row of cursor, 0..ROWS-1
//     cursor_col   cursor column, 0..COLS-1
//     scroll_base  physical row shown as screen row 0
//     busy         high while clearing the whole screen or a line
module term_text_writer #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        wr_en,
   output logic [13:0] wr_addr,
   output logic [6:0]  wr_data,
   output logic [6:0]  cursor_row,
   output logic [6:0]  cursor_col,
   output logic [6:0]  scroll_base,
   output logic        busy
);

   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [6:0]  LAST_ROW  = 7'(ROWS - 1);
   localparam logic [13:0] LAST_ADDR = {LAST_ROW, LAST_COL};
   localparam logic [6:0]  SPACE     = 7'h20;

   typedef enum logic [1:0] {
      CLR_ALL,
      IDLE,
      EXEC,
      CLR_LINE
   } state_t;

   state_t      state, state_nxt;
   logic [6:0]  clr_row, clr_row_nxt;
   logic [6:0]  clr_col, clr_col_nxt;
   logic [6:0]  row_nxt, col_nxt, base_nxt;
   logic        scroll_pend, scroll_pend_nxt;
   logic        wr_en_nxt, rx_ready_nxt, busy_nxt;
   logic [13:0] wr_addr_nxt;
   logic [6:0]  wr_data_nxt;
   logic        newline;
   logic [7:0]  phys_sum;
   logic [6:0]  phys_row;

   // Physical row of the cursor: (scroll_base + cursor_row) mod ROWS.
   // Both operands are below ROWS, so a single conditional subtract suffices.
   assign phys_sum = {1'b0, scroll_base} + {1'b0, cursor_row};

   always_comb begin
      if (phys_sum >= 8'(ROWS))
         phys_row = 7'(phys_sum - 8'(ROWS));
      else
         phys_row = phys_sum[6:0];
   end

   // Every output is a register; this block computes the value each output
   // takes in the state being entered, so the write strobe is visible during
   // the EXEC / clear cycles themselves rather than one cycle late.
   always_comb begin
      state_nxt       = state;
      clr_row_nxt     = clr_row;
      clr_col_nxt     = clr_col;
      row_nxt         = cursor_row;
      col_nxt         = cursor_col;
      base_nxt        = scroll_base;
      scroll_pend_nxt = scroll_pend;
      wr_en_nxt       = 1'b0;
      wr_addr_nxt     = wr_addr;
      wr_data_nxt     = wr_data;
      rx_ready_nxt    = 1'b0;
      busy_nxt        = 1'b0;
      newline         = 1'b0;

      case (state)
         CLR_ALL: begin
            // The sweep ends once the last cell's write has been presented.
            if (wr_en && (wr_addr == LAST_ADDR)) begin
               state_nxt    = IDLE;
               rx_ready_nxt = 1'b1;
               clr_row_nxt  = '0;
               clr_col_nxt  = '0;
            end else begin
               busy_nxt    = 1'b1;
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = {clr_row, clr_col};
               wr_data_nxt = SPACE;
               if (clr_col == LAST_COL) begin
                  clr_col_nxt = '0;
                  clr_row_nxt = clr_row + 7'd1;
               end else begin
                  clr_col_nxt = clr_col + 7'd1;
               end
            end
         end

         IDLE: begin
            rx_ready_nxt = 1'b1;
            if (rx_valid && rx_ready) begin
               rx_ready_nxt = 1'b0;
               state_nxt    = EXEC;
               if ((rx_data >= 8'h20) && (rx_data <= 8'h7E)) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = {phys_row, cursor_col};
                  wr_data_nxt = rx_data[6:0];
                  if (cursor_col == LAST_COL) begin
                     col_nxt = '0;
                     newline = 1'b1;
                  end else begin
                     col_nxt = cursor_col + 7'd1;
                  end
               end else if (rx_data == 8'h0D) begin
                  col_nxt = '0;
               end else if (rx_data == 8'h0A) begin
                  newline = 1'b1;
               end else if ((rx_data == 8'h08) && (cursor_col != 7'd0)) begin
                  col_nxt     = cursor_col - 7'd1;
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = {phys_row, cursor_col - 7'd1};
                  wr_data_nxt = SPACE;
               end

               if (newline) begin
                  if (cursor_row != LAST_ROW) begin
                     row_nxt = cursor_row + 7'd1;
                  end else begin
                     // The old top physical row becomes the new bottom line.
                     base_nxt        = (scroll_base == LAST_ROW) ? '0 : scroll_base + 7'd1;
                     clr_row_nxt     = scroll_base;
                     scroll_pend_nxt = 1'b1;
                  end
               end
            end
         end

         EXEC: begin
            if (scroll_pend) begin
               scroll_pend_nxt = 1'b0;
               state_nxt       = CLR_LINE;
               busy_nxt        = 1'b1;
               wr_en_nxt       = 1'b1;
               wr_addr_nxt     = {clr_row, 7'd0};
               wr_data_nxt     = SPACE;
               clr_col_nxt     = 7'd1;
            end else begin
               state_nxt    = IDLE;
               rx_ready_nxt = 1'b1;
            end
         end

         CLR_LINE: begin
            if (wr_addr[6:0] == LAST_COL) begin
               state_nxt    = IDLE;
               rx_ready_nxt = 1'b1;
               clr_row_nxt  = '0;
               clr_col_nxt  = '0;
            end else begin
               busy_nxt    = 1'b1;
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = {clr_row, clr_col};
               wr_data_nxt = SPACE;
               clr_col_nxt = clr_col + 7'd1;
            end
         end

         default: begin
            state_nxt = CLR_ALL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= CLR_ALL;
         clr_row     <= '0;
         clr_col     <= '0;
         cursor_row  <= '0;
         cursor_col  <= '0;
         scroll_base <= '0;
         scroll_pend <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         rx_ready    <= 1'b0;
         busy        <= 1'b1;
      end else begin
         state       <= state_nxt;
         clr_row     <= clr_row_nxt;
         clr_col     <= clr_col_nxt;
         cursor_row  <= row_nxt;
         cursor_col  <= col_nxt;
         scroll_base <= base_nxt;
         scroll_pend <= scroll_pend_nxt;
         wr_en       <= wr_en_nxt;
         wr_addr     <= wr_addr_nxt;
         wr_data     <= wr_data_nxt;
         rx_ready    <= rx_ready_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_term_text_writer.sv
// tb_term_text_writer
//   Scoreboard bench for term_text_writer (COLS=80, ROWS=30). Expected RAM
//   writes are queued as stimulus is issued; a monitor pops and compares on
//   every wr_en cycle. Cursor / handshake values are checked directly.
module tb_term_text_writer;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [13:0] wr_addr;
   logic [6:0]  wr_data;
   logic [6:0]  cursor_row;
   logic [6:0]  cursor_col;
   logic [6:0]  scroll_base;
   logic        busy;

   typedef struct packed {
      logic [13:0] addr;
      logic [6:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  wcount      = 0;

   term_text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .cursor_row  (cursor_row),
      .cursor_col  (cursor_col),
      .scroll_base (scroll_base),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input int addr, input int data);
      exp_q.push_back({14'(addr), 7'(data)});
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset && wr_en) begin
            wcount++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none queued", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", int'(wr_addr), int'(e.addr));
               check("wr_data", int'(wr_data), int'(e.data));
            end
         end
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      @(negedge clk);
      while (!rx_ready && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_ready", int'(rx_ready), 1);
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check("send_timeout", int'(rx_ready), 1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic push_sweep();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            push(r * 128 + c, 'h20);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int n;
      int nb;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      fork
         monitor();
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_wr_en",    int'(wr_en), 0);
      check("rst_wr_addr",  int'(wr_addr), 0);
      check("rst_wr_data",  int'(wr_data), 0);
      check("rst_rx_ready", int'(rx_ready), 0);
      check("rst_busy",     int'(busy), 1);
      check("rst_cursor",   int'({cursor_row, cursor_col}), 0);
      check("rst_base",     int'(scroll_base), 0);

      // Full-screen clear: 2400 writes 0x000 .. 0xECF
      push_sweep();
      @(posedge clk);
      #1 reset = 1'b0;
      w0 = wcount;
      wait_idle(3000);
      check("init_writes", wcount - w0, 2400);
      check("init_q_left", exp_q.size(), 0);
      check("init_busy",   int'(busy), 0);

      // Single 'A': written during the EXEC cycle, rx_ready low for 1 cycle
      push('h000, 'h41);
      send(8'h41);
      @(negedge clk);
      check("exec_rx_ready", int'(rx_ready), 0);
      check("exec_wr_en",    int'(wr_en), 1);
      check("exec_col",      int'(cursor_col), 1);
      @(negedge clk);
      check("after_rx_ready", int'(rx_ready), 1);

      // "AB" CR LF "C" -> C at row 1 col 0
      push('h001, 'h41); send(8'h41);
      push('h002, 'h42); send(8'h42);
      send(8'h0D);
      send(8'h0A);
      push('h080, 'h43); send(8'h43);
      wait_idle(10);
      check("crlf_row", int'(cursor_row), 1);
      check("crlf_col", int'(cursor_col), 1);

      // BS at col 0 is a no-op; BS at col 5 blanks col 4
      send(8'h0D);
      send(8'h08);
      wait_idle(10);
      check("bs0_col", int'(cursor_col), 0);
      check("bs0_row", int'(cursor_row), 1);
      push('h080, 'h68); send(8'h68);
      push('h081, 'h65); send(8'h65);
      push('h082, 'h6C); send(8'h6C);
      push('h083, 'h6C); send(8'h6C);
      push('h084, 'h6F); send(8'h6F);
      push('h084, 'h20); send(8'h08);
      wait_idle(10);
      check("bs5_col", int'(cursor_col), 4);

      // Non-printables outside CR/LF/BS are ignored
      send(8'h7F);
      send(8'h01);
      send(8'hC1);
      wait_idle(10);
      check("ign_col", int'(cursor_col), 4);
      check("ign_row", int'(cursor_row), 1);

      // 80 printables from col 0 -> wrap to next row, no line clear
      send(8'h0D);
      for (int i = 0; i < COLS; i++) begin
         push('h080 + i, 'h21 + i);
         send(8'(8'h21 + i));
      end
      wait_idle(10);
      check("wrap_row",  int'(cursor_row), 2);
      check("wrap_col",  int'(cursor_col), 0);
      check("wrap_base", int'(scroll_base), 0);
      check("wrap_q",    exp_q.size(), 0);

      // Walk down to the last row, then LF scrolls
      for (int i = 0; i < 27; i++) send(8'h0A);
      wait_idle(10);
      check("bottom_row", int'(cursor_row), 29);
      for (int i = 0; i < COLS; i++) push(i, 'h20);
      send(8'h0A);
      n  = 0;
      nb = 0;
      while (n < 500) begin
         @(negedge clk);
         if (rx_ready) break;
         n++;
         if (busy) nb++;
      end
      check("scroll_cycles", n, COLS + 1);
      check("scroll_busy",   nb, COLS);
      check("scroll_base",   int'(scroll_base), 1);
      check("scroll_row",    int'(cursor_row), 29);
      check("scroll_q",      exp_q.size(), 0);
      push('h000, 'h58);
      send(8'h58);
      wait_idle(10);
      check("x_col", int'(cursor_col), 1);
      check("x_row", int'(cursor_row), 29);

      // Reset in the middle of the full-screen clear
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst2_base", int'(scroll_base), 0);
      exp_q.delete();
      push_sweep();
      @(posedge clk);
      #1 reset = 1'b0;
      w0 = wcount;
      n  = 0;
      while (n < 3000) begin
         @(posedge clk);
         #2;
         if (wcount - w0 >= 1000) break;
         n++;
      end
      check("abort_count", wcount - w0, 1000);
      check("abort_wr_en_before", int'(wr_en), 1);
      reset = 1'b1;
      #1;
      check("abort_wr_en_async", int'(wr_en), 0);
      exp_q.delete();
      push_sweep();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      w0 = wcount;
      wait_idle(3000);
      check("restart_writes", wcount - w0, 2400);
      check("restart_q",      exp_q.size(), 0);
      check("restart_cursor", int'({cursor_row, cursor_col}), 0);

      repeat (2) @(negedge clk);
      check("final_q", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
